// File: rtl/a2_bridge_target_if.sv
// Bridge-target signal bundle: host cycle queue, A2Bridge byte-mux lines and read responses.
// slave is the target itself; master is whatever drives it (host plus card front end).
interface a2_bridge_target_if;
  logic        run_i;
  logic        cyc_valid_i;
  logic        cyc_ready_o;
  logic [15:0] cyc_addr_i;
  logic        cyc_rw_n_i;
  logic [7:0]  cyc_data_i;
  logic        a2_phi1_o;
  logic [1:0]  a2_bridge_sel_i;
  logic        a2_bridge_bus_a_oe_i;
  logic        a2_bridge_bus_d_oe_i;
  logic        a2_bridge_rd_i;
  logic        a2_bridge_wr_i;
  logic [7:0]  a2_bridge_d_i;
  logic [7:0]  a2_bridge_d_o;
  logic        a2_bridge_d_oe_o;
  logic        resp_valid_o;
  logic [15:0] resp_addr_o;
  logic        resp_driven_o;
  logic [7:0]  resp_data_o;
  logic        err_o;

  modport slave (
    input  run_i, cyc_valid_i, cyc_addr_i, cyc_rw_n_i, cyc_data_i,
    input  a2_bridge_sel_i, a2_bridge_bus_a_oe_i, a2_bridge_bus_d_oe_i,
    input  a2_bridge_rd_i, a2_bridge_wr_i, a2_bridge_d_i,
    output cyc_ready_o, a2_phi1_o, a2_bridge_d_o, a2_bridge_d_oe_o,
    output resp_valid_o, resp_addr_o, resp_driven_o, resp_data_o, err_o
  );

  modport master (
    output run_i, cyc_valid_i, cyc_addr_i, cyc_rw_n_i, cyc_data_i,
    output a2_bridge_sel_i, a2_bridge_bus_a_oe_i, a2_bridge_bus_d_oe_i,
    output a2_bridge_rd_i, a2_bridge_wr_i, a2_bridge_d_i,
    input  cyc_ready_o, a2_phi1_o, a2_bridge_d_o, a2_bridge_d_oe_o,
    input  resp_valid_o, resp_addr_o, resp_driven_o, resp_data_o, err_o
  );
endinterface

// File: rtl/a2_bridge_target.sv
// Far-end responder of the A2Bridge byte-mux link: sequences queued Apple II bus cycles,
// generates phi1, serves address/control/data bytes and captures bytes the card drives back.
module a2_bridge_target #(
  parameter int unsigned PHI_HALF_CYCLES = 27,
  parameter int unsigned READ_LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter logic [3:0]  DIP_SWITCHES_N  = 4'hF
) (
  input logic               clk_logic,
  input logic               reset,
  a2_bridge_target_if.slave bus
);
  localparam int unsigned CNT_W = (PHI_HALF_CYCLES > 1) ? $clog2(PHI_HALF_CYCLES) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LAT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHI_HALF_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_DONE = LAT_W'(READ_LATENCY);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {S_PHI1, S_PHI0} phase_e;

  phase_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             enter_phi0, leave_phi0;

  logic [24:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nx;
  logic             full, empty, push, pop;

  logic [15:0]      cur_addr;
  logic             cur_rw_n;
  logic [7:0]       cur_data;
  logic [7:0]       mux_byte;

  logic [LAT_W-1:0] lat_cnt, lat_nx;
  logic             oe_q, oe_nx;
  logic [7:0]       d_q;

  logic             cap_hit, cap_driven, cap_drv_nx;
  logic [7:0]       cap_data, cap_data_nx;
  logic             err_hit;

  // Phase sequencer: with run_i low, PHI0 still finishes, then PHI1 parks with the counter at 0.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    enter_phi0 = 1'b0;
    leave_phi0 = 1'b0;
    unique case (state)
      S_PHI1: begin
        if (!bus.run_i) begin
          cnt_nx = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx   = S_PHI0;
          cnt_nx     = '0;
          enter_phi0 = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_PHI0: begin
        if (cnt == CNT_LAST) begin
          state_nx   = S_PHI1;
          cnt_nx     = '0;
          leave_phi0 = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      state <= S_PHI1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign bus.a2_phi1_o = (state == S_PHI1);

  // Pending-cycle queue; ready comes from the registered full flag.
  assign empty = (count == '0);
  assign push  = bus.cyc_valid_i && !full;
  assign pop   = enter_phi0 && !empty;
  assign bus.cyc_ready_o = !full;

  always_comb begin
    count_nx = count;
    if (push && !pop) begin
      count_nx = count + 1'b1;
    end else if (pop && !push) begin
      count_nx = count - 1'b1;
    end
  end

  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
      full  <= (count_nx == CNT_FULL);
    end
  end

  always_ff @(posedge clk_logic) begin
    if (push) fifo_mem[wr_ptr] <= {bus.cyc_addr_i, bus.cyc_rw_n_i, bus.cyc_data_i};
  end

  // An empty queue yields an idle read of 16'hFFFF so phi keeps running.
  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      cur_addr <= '1;
      cur_rw_n <= 1'b1;
      cur_data <= '1;
    end else if (enter_phi0) begin
      if (empty) begin
        {cur_addr, cur_rw_n, cur_data} <= {16'hFFFF, 1'b1, 8'hFF};
      end else begin
        {cur_addr, cur_rw_n, cur_data} <= fifo_mem[rd_ptr];
      end
    end
  end

  always_comb begin
    mux_byte = 8'hFF;
    case (bus.a2_bridge_sel_i)
      2'd0: if (!bus.a2_bridge_bus_a_oe_i) mux_byte = cur_addr[7:0];
      2'd1: if (!bus.a2_bridge_bus_a_oe_i) mux_byte = cur_addr[15:8];
      2'd2: mux_byte = {DIP_SWITCHES_N, 3'b000, cur_rw_n};
      2'd3: if (!bus.a2_bridge_bus_d_oe_i && !cur_rw_n) mux_byte = cur_data;
    endcase
  end

  // Latency counter saturates at READ_LATENCY; it restarts whenever rd is low.
  always_comb begin
    lat_nx = '0;
    if (bus.a2_bridge_rd_i) begin
      lat_nx = (lat_cnt == LAT_DONE) ? lat_cnt : lat_cnt + 1'b1;
    end
    oe_nx = bus.a2_bridge_rd_i && !bus.a2_bridge_wr_i && (lat_nx == LAT_DONE);
  end

  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      lat_cnt <= '0;
      oe_q    <= 1'b0;
      d_q     <= 8'hFF;
    end else begin
      lat_cnt <= lat_nx;
      oe_q    <= oe_nx;
      d_q     <= oe_nx ? mux_byte : 8'hFF;
    end
  end

  // The drive enable is also gated combinationally so a rd/wr collision never drives.
  assign bus.a2_bridge_d_o    = d_q;
  assign bus.a2_bridge_d_oe_o = oe_q && !(bus.a2_bridge_rd_i && bus.a2_bridge_wr_i);

  assign cap_hit     = (state == S_PHI0) && cur_rw_n && bus.a2_bridge_wr_i && !bus.a2_bridge_bus_d_oe_i;
  assign cap_data_nx = cap_hit ? bus.a2_bridge_d_i : cap_data;
  assign cap_drv_nx  = cap_hit || cap_driven;

  // A byte captured on the terminal PHI0 cycle still lands in that cycle's response.
  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      cap_data      <= 8'hFF;
      cap_driven    <= 1'b0;
      bus.resp_valid_o  <= 1'b0;
      bus.resp_addr_o   <= '0;
      bus.resp_driven_o <= 1'b0;
      bus.resp_data_o   <= '0;
    end else begin
      bus.resp_valid_o <= 1'b0;
      if (leave_phi0) begin
        cap_data   <= 8'hFF;
        cap_driven <= 1'b0;
        if (cur_rw_n) begin
          bus.resp_valid_o  <= 1'b1;
          bus.resp_addr_o   <= cur_addr;
          bus.resp_driven_o <= cap_drv_nx;
          bus.resp_data_o   <= cap_data_nx;
        end
      end else if (cap_hit) begin
        cap_data   <= bus.a2_bridge_d_i;
        cap_driven <= 1'b1;
      end
    end
  end

  assign err_hit = (bus.a2_bridge_rd_i && bus.a2_bridge_wr_i)
                || (bus.a2_bridge_wr_i && !bus.a2_bridge_bus_d_oe_i && !cur_rw_n)
                || (bus.a2_bridge_wr_i && (state == S_PHI1));

  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      bus.err_o <= 1'b0;
    end else if (err_hit) begin
      bus.err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_a2_bridge_target.sv
// Bench for a2_bridge_target: byte-mux vector table, hand sequences for reset/stop/capture/error,
// and a randomized run scored against a queue-based model of the cycle sequencing.
module tb_a2_bridge_target;
  localparam int unsigned PH    = 8;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  logic clk_logic = 1'b0;
  logic reset;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  a2_bridge_target_if bus ();

  a2_bridge_target #(
    .PHI_HALF_CYCLES(PH),
    .READ_LATENCY(LAT),
    .FIFO_DEPTH(DEPTH),
    .DIP_SWITCHES_N(4'hF)
  ) dut (
    .clk_logic(clk_logic),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk_logic = ~clk_logic;

  typedef struct {
    logic [15:0] addr;
    logic        rw_n;
    logic [7:0]  data;
    logic [1:0]  sel;
    logic        a_oe;
    logic        d_oe;
    logic [7:0]  exp;
  } mux_vec_t;

  typedef struct {
    logic [15:0] addr;
    logic        rw_n;
    logic [7:0]  data;
  } cyc_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_logic);
  endtask

  task automatic wait_phi(input logic level, input string name);
    int unsigned n = 0;
    while (bus.a2_phi1_o !== level && n < 8 * PH) begin
      tick();
      n++;
    end
    if (bus.a2_phi1_o !== level) check(name, 32'(bus.a2_phi1_o), 32'(level));
  endtask

  task automatic push(input logic [15:0] a, input logic rw_n, input logic [7:0] d);
    bus.cyc_valid_i = 1'b1;
    bus.cyc_addr_i  = a;
    bus.cyc_rw_n_i  = rw_n;
    bus.cyc_data_i  = d;
    tick();
    bus.cyc_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input string name, output logic [15:0] a, output logic [7:0] d,
                           output logic drv);
    int unsigned n = 0;
    while (bus.resp_valid_o !== 1'b1 && n < 8 * PH) begin
      tick();
      n++;
    end
    check({name, "_seen"}, 32'(bus.resp_valid_o), 32'd1);
    a   = bus.resp_addr_o;
    d   = bus.resp_data_o;
    drv = bus.resp_driven_o;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mux_vec_t    vecs [10];
    cyc_t        q [$];
    cyc_t        cur, pend;
    logic        pend_v, prev, phi, cap_drv, seen, drain;
    logic [7:0]  cap_d, rd_d;
    logic [15:0] rd_a;
    logic        rd_drv;
    int unsigned low, n;

    vecs[0] = '{16'hC0A5, 1'b1, 8'h00, 2'd0, 1'b0, 1'b1, 8'hA5};
    vecs[1] = '{16'hC0A5, 1'b1, 8'h00, 2'd1, 1'b0, 1'b1, 8'hC0};
    vecs[2] = '{16'hC0A5, 1'b1, 8'h00, 2'd2, 1'b1, 1'b1, 8'hF1};
    vecs[3] = '{16'hC0A5, 1'b1, 8'h00, 2'd0, 1'b1, 1'b1, 8'hFF};
    vecs[4] = '{16'hC0A5, 1'b1, 8'h00, 2'd1, 1'b1, 1'b1, 8'hFF};
    vecs[5] = '{16'hC0A5, 1'b1, 8'h00, 2'd3, 1'b1, 1'b0, 8'hFF};
    vecs[6] = '{16'h0400, 1'b0, 8'h41, 2'd3, 1'b1, 1'b0, 8'h41};
    vecs[7] = '{16'h0400, 1'b0, 8'h41, 2'd3, 1'b1, 1'b1, 8'hFF};
    vecs[8] = '{16'h0400, 1'b0, 8'h41, 2'd2, 1'b1, 1'b1, 8'hF0};
    vecs[9] = '{16'h0400, 1'b0, 8'h41, 2'd0, 1'b0, 1'b1, 8'h00};

    bus.run_i                = 1'b0;
    bus.cyc_valid_i          = 1'b0;
    bus.cyc_addr_i           = '0;
    bus.cyc_rw_n_i           = 1'b1;
    bus.cyc_data_i           = '0;
    bus.a2_bridge_sel_i      = 2'd0;
    bus.a2_bridge_bus_a_oe_i = 1'b1;
    bus.a2_bridge_bus_d_oe_i = 1'b1;
    bus.a2_bridge_rd_i       = 1'b0;
    bus.a2_bridge_wr_i       = 1'b0;
    bus.a2_bridge_d_i        = '0;
    reset = 1'b1;
    repeat (3) tick();

    check("rst_phi1",        32'(bus.a2_phi1_o),        32'd1);
    check("rst_ready",       32'(bus.cyc_ready_o),      32'd1);
    check("rst_d_o",         32'(bus.a2_bridge_d_o),    32'hFF);
    check("rst_d_oe",        32'(bus.a2_bridge_d_oe_o), 32'd0);
    check("rst_resp_valid",  32'(bus.resp_valid_o),     32'd0);
    check("rst_resp_addr",   32'(bus.resp_addr_o),      32'd0);
    check("rst_resp_data",   32'(bus.resp_data_o),      32'd0);
    check("rst_resp_driven", 32'(bus.resp_driven_o),    32'd0);
    check("rst_err",         32'(bus.err_o),            32'd0);
    reset = 1'b0;
    tick();

    // Stopped: five pushes, only four fit.
    for (int unsigned i = 0; i < 5; i++) begin
      check("stop_ready_before_push", 32'(bus.cyc_ready_o), (i < DEPTH) ? 32'd1 : 32'd0);
      push(16'h1000 + 16'(i), 1'b1, 8'h00);
    end
    check("stop_ready_full", 32'(bus.cyc_ready_o), 32'd0);
    check("stop_phi1_held",  32'(bus.a2_phi1_o),   32'd1);

    // Reset in the middle of PHI0 flushes everything without a response.
    bus.run_i = 1'b1;
    wait_phi(1'b0, "rstmid_fall_timeout");
    repeat (3) tick();
    reset = 1'b1;
    seen  = 1'b0;
    repeat (PH + 2) begin
      tick();
      if (bus.resp_valid_o === 1'b1) seen = 1'b1;
    end
    check("rstmid_no_resp", 32'(seen),             32'd0);
    check("rstmid_phi1",    32'(bus.a2_phi1_o),    32'd1);
    check("rstmid_ready",   32'(bus.cyc_ready_o),  32'd1);
    reset = 1'b0;
    wait_resp("idle_resp", rd_a, rd_d, rd_drv);
    check("idle_addr",   32'(rd_a),   32'hFFFF);
    check("idle_data",   32'(rd_d),   32'hFF);
    check("idle_driven", 32'(rd_drv), 32'd0);

    // Byte mux vectors, one bus cycle per vector.
    foreach (vecs[i]) begin
      wait_phi(1'b0, "mux_fall_timeout");
      wait_phi(1'b1, "mux_rise_timeout");
      push(vecs[i].addr, vecs[i].rw_n, vecs[i].data);
      wait_phi(1'b0, "mux_phi0_timeout");
      bus.a2_bridge_sel_i      = vecs[i].sel;
      bus.a2_bridge_bus_a_oe_i = vecs[i].a_oe;
      bus.a2_bridge_bus_d_oe_i = vecs[i].d_oe;
      bus.a2_bridge_rd_i       = 1'b1;
      tick();
      check($sformatf("mux%0d_oe_early", i), 32'(bus.a2_bridge_d_oe_o), 32'd0);
      tick();
      check($sformatf("mux%0d_oe", i),   32'(bus.a2_bridge_d_oe_o), 32'd1);
      check($sformatf("mux%0d_byte", i), 32'(bus.a2_bridge_d_o),    32'(vecs[i].exp));
      bus.a2_bridge_rd_i = 1'b0;
      tick();
      check($sformatf("mux%0d_oe_drop", i), 32'(bus.a2_bridge_d_oe_o), 32'd0);
      bus.a2_bridge_bus_a_oe_i = 1'b1;
      bus.a2_bridge_bus_d_oe_i = 1'b1;
    end

    // Card drives two bytes in PHI0 of a read; the later one is reported.
    wait_phi(1'b0, "cap_fall_timeout");
    wait_phi(1'b1, "cap_rise_timeout");
    push(16'hC0F0, 1'b1, 8'h00);
    wait_phi(1'b0, "cap_phi0_timeout");
    tick();
    bus.a2_bridge_wr_i       = 1'b1;
    bus.a2_bridge_bus_d_oe_i = 1'b0;
    bus.a2_bridge_d_i        = 8'h33;
    tick();
    bus.a2_bridge_d_i = 8'h5A;
    tick();
    bus.a2_bridge_wr_i       = 1'b0;
    bus.a2_bridge_bus_d_oe_i = 1'b1;
    wait_resp("cap_resp", rd_a, rd_d, rd_drv);
    check("cap_addr",       32'(rd_a),           32'hC0F0);
    check("cap_data",       32'(rd_d),           32'h5A);
    check("cap_driven",     32'(rd_drv),         32'd1);
    check("cap_phi1_rose",  32'(bus.a2_phi1_o),  32'd1);
    tick();
    check("cap_pulse_once", 32'(bus.resp_valid_o), 32'd0);
    check("cap_no_err",     32'(bus.err_o),        32'd0);

    // run_i dropped mid-PHI0: PHI0 completes, phi1 parks high, restart takes a full half period.
    wait_phi(1'b1, "run_rise_timeout");
    wait_phi(1'b0, "run_fall_timeout");
    low = 1;
    n   = 0;
    while (n < 4 * PH) begin
      if (n == 2) bus.run_i = 1'b0;
      tick();
      n++;
      if (bus.a2_phi1_o === 1'b0) low++;
      else break;
    end
    check("run_phi0_len", low, PH);
    low = 0;
    repeat (3 * PH) begin
      tick();
      if (bus.a2_phi1_o !== 1'b1) low++;
    end
    check("run_parked_low_samples", low, 32'd0);
    bus.run_i = 1'b1;
    n = 0;
    while (bus.a2_phi1_o !== 1'b0 && n < 4 * PH) begin
      tick();
      n++;
    end
    check("run_restart_delay", n, PH);

    // Randomized traffic scored against a queue model of pop-at-fall / respond-at-rise.
    wait_phi(1'b1, "rnd_start_timeout");
    prev    = 1'b1;
    pend_v  = 1'b0;
    cap_drv = 1'b0;
    cap_d   = 8'hFF;
    cur     = '{16'hFFFF, 1'b1, 8'hFF};
    for (int unsigned t = 0; t < 3000; t++) begin
      tick();
      drain = (t >= 2400);
      phi   = bus.a2_phi1_o;
      if (prev && !phi) begin
        if (q.size() > 0) cur = q.pop_front();
        else cur = '{16'hFFFF, 1'b1, 8'hFF};
        cap_drv = 1'b0;
        cap_d   = 8'hFF;
      end
      if (!prev && phi) begin
        if (cur.rw_n) begin
          check("rnd_resp_valid",  32'(bus.resp_valid_o),  32'd1);
          check("rnd_resp_addr",   32'(bus.resp_addr_o),   32'(cur.addr));
          check("rnd_resp_driven", 32'(bus.resp_driven_o), 32'(cap_drv));
          check("rnd_resp_data",   32'(bus.resp_data_o),   cap_drv ? 32'(cap_d) : 32'hFF);
        end else begin
          check("rnd_write_no_resp", 32'(bus.resp_valid_o), 32'd0);
        end
      end else begin
        check("rnd_resp_stray", 32'(bus.resp_valid_o), 32'd0);
      end
      if (pend_v) q.push_back(pend);
      pend_v = 1'b0;

      bus.cyc_valid_i = !drain && ($urandom_range(0, 2) == 0);
      bus.cyc_addr_i  = 16'($urandom);
      bus.cyc_rw_n_i  = 1'($urandom_range(0, 1));
      bus.cyc_data_i  = 8'($urandom);
      if (bus.cyc_valid_i && bus.cyc_ready_o) begin
        pend   = '{bus.cyc_addr_i, bus.cyc_rw_n_i, bus.cyc_data_i};
        pend_v = 1'b1;
      end

      bus.a2_bridge_wr_i       = 1'b0;
      bus.a2_bridge_bus_d_oe_i = 1'b1;
      if (!phi && !drain && $urandom_range(0, 3) == 0) begin
        bus.a2_bridge_wr_i       = 1'b1;
        bus.a2_bridge_d_i        = 8'($urandom);
        bus.a2_bridge_bus_d_oe_i = cur.rw_n ? 1'($urandom_range(0, 1)) : 1'b1;
        if (cur.rw_n && !bus.a2_bridge_bus_d_oe_i) begin
          cap_drv = 1'b1;
          cap_d   = bus.a2_bridge_d_i;
        end
      end
      if (drain) bus.run_i = 1'b1;
      else if ($urandom_range(0, 39) == 0) bus.run_i = !bus.run_i;
      prev = phi;
    end
    bus.cyc_valid_i    = 1'b0;
    bus.a2_bridge_wr_i = 1'b0;
    check("rnd_err_clear",   32'(bus.err_o),       32'd0);
    check("rnd_fifo_drained", 32'(bus.cyc_ready_o), 32'd1);

    // rd/wr collision forces the drive enable off and latches a sticky error.
    bus.a2_bridge_sel_i = 2'd2;
    bus.a2_bridge_rd_i  = 1'b1;
    repeat (LAT + 1) tick();
    check("err_oe_before", 32'(bus.a2_bridge_d_oe_o), 32'd1);
    bus.a2_bridge_wr_i = 1'b1;
    #1;
    check("err_oe_forced", 32'(bus.a2_bridge_d_oe_o), 32'd0);
    tick();
    check("err_set",       32'(bus.err_o),            32'd1);
    check("err_oe_held",   32'(bus.a2_bridge_d_oe_o), 32'd0);
    bus.a2_bridge_wr_i = 1'b0;
    bus.a2_bridge_rd_i = 1'b0;
    repeat (5) tick();
    check("err_sticky", 32'(bus.err_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/a2_bridge_target.md
Name: a2_bridge_target

Overview:
- Synthesizable responder for the far end of the A2Bridge byte-mux interface: the side that the card's bus front end (apple_bus) drives as initiator.
- Queues Apple II bus cycles from a host or bench and generates phi1.
- Serves address, control and data bytes on the bridge data lines according to sel/rd, and captures bytes the card drives back during read cycles.
- Used for board bring-up loopback and for closed-loop simulation of the card without an Apple II.

Parameters:
- PHI_HALF_CYCLES, 27: clk_logic cycles per phi half-period (54 MHz gives about 1 MHz phi).
- READ_LATENCY, 2: clk_logic cycles from rd rising to d_oe/d_o valid; range 1..7.
- FIFO_DEPTH, 4: pending-cycle queue depth; power of 2, at least 2.
- DIP_SWITCHES_N, 4'hF: value reported in control byte bits [7:4].

Ports:
- clk_logic  in  1  logic clock
- reset  in  1  asynchronous, active-high
- run_i  in  1  1 = sequence bus cycles; 0 = stop clock with phi1 held high
- cyc_valid_i  in  1  push request for a queued cycle
- cyc_ready_o  out  1  FIFO not full
- cyc_addr_i  in  16  cycle address
- cyc_rw_n_i  in  1  1 = read, 0 = write
- cyc_data_i  in  8  write data (ignored for reads)
- a2_phi1_o  out  1  generated phi1
- a2_bridge_sel_i  in  2  byte select
- a2_bridge_bus_a_oe_i  in  1  address buffer enable, active low
- a2_bridge_bus_d_oe_i  in  1  data buffer enable, active low
- a2_bridge_rd_i  in  1  byte read strobe, active high
- a2_bridge_wr_i  in  1  card drive strobe, active high
- a2_bridge_d_i  in  8  byte driven by card
- a2_bridge_d_o  out  8  byte served to card
- a2_bridge_d_oe_o  out  1  output enable for a2_bridge_d_o
- resp_valid_o  out  1  one-cycle pulse at end of each read cycle
- resp_addr_o  out  16  address of the completed read cycle
- resp_driven_o  out  1  card drove data during that cycle
- resp_data_o  out  8  captured byte, 8'hFF if not driven
- err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset values: a2_phi1_o=1, sequencer in PHI1 with counter 0, FIFO empty, cyc_ready_o=1, a2_bridge_d_o=8'hFF, a2_bridge_d_oe_o=0, resp_valid_o=0, resp_*=0, err_o=0.
- Reset asserted mid-operation flushes the FIFO, drops the in-flight cycle and emits no resp_valid_o.
- FIFO:
  - Push when cyc_valid_i && cyc_ready_o.
  - Simultaneous push and pop when full is not allowed, because ready is computed from the registered full flag.
  - Pop occurs only at the PHI1-to-PHI0 transition.
- Sequencer: states PHI1 and PHI0; the counter runs 0..PHI_HALF_CYCLES-1, and the state toggles on the terminal count.
- Entering PHI0:
  - If the FIFO is non-empty, pop the head into the current-cycle register.
  - If it is empty, load an idle read cycle: addr 16'hFFFF, rw_n=1. Idle cycles still emit resp_valid_o.
  - a2_phi1_o = 0 during PHI0.
- run_i=0: the sequencer completes any PHI0 in progress, then holds PHI1 with the counter frozen at 0. On run_i=1 counting resumes from 0.
- Byte mux (current-cycle register):
  - sel 0 gives addr[7:0]; sel 1 gives addr[15:8]. Both read 8'hFF when bus_a_oe_i=1.
  - sel 2 gives {DIP_SWITCHES_N, 3'b000, rw_n}.
  - sel 3 gives write data for write cycles, 8'hFF for read cycles or when bus_d_oe_i=1.
- Read handshake:
  - The rd rising edge starts a latency counter. Once READ_LATENCY cycles have elapsed, d_oe_o=1 with d_o=mux(sel) sampled each cycle.
  - d_oe_o drops the cycle after rd falls.
  - If rd falls before latency completes, d_oe_o is never asserted.
- Capture: during PHI0 of a read cycle, each cycle with wr_i=1 and bus_d_oe_i=0 latches d_i and sets driven. The last such byte wins.
- Response: on the PHI0 terminal count of a read cycle, resp_valid_o pulses for one cycle with the latched data, or 8'hFF and driven=0 if nothing was captured. The capture latch then clears.
- err_o is set (sticky until reset) on any of:
  - rd_i && wr_i in the same cycle; d_oe_o is forced 0 while both are high.
  - wr_i && !bus_d_oe_i during a write cycle (bus contention).
  - wr_i during PHI1.

Test Plan:
- Push read of 16'hC0A5; during PHI0 pulse rd with sel 0, 1, 2 -> after 2 clk d_o = 8'hA5, 8'hC0, 8'hF1; d_oe asserted only after latency.
- Push write 16'h0400/8'h41, then rd with sel 3 and bus_d_oe=0 -> d_o=8'h41; with bus_d_oe=1 -> 8'hFF.
- Read of 16'hC0F0; card asserts wr with d_i=8'h5A in PHI0 -> resp_valid one pulse at PHI0 end, resp_addr=16'hC0F0, resp_data=8'h5A, driven=1.
- FIFO empty -> idle cycle 16'hFFFF with resp_driven=0 and resp_data=8'hFF. Push 5 cycles while stopped -> cyc_ready_o=0 after 4 are queued.
- rd and wr both high for one clk -> err_o=1, d_oe_o=0, err_o persists. Assert reset mid-PHI0 -> no resp_valid, phi1=1, FIFO empty.
- run_i=0 mid-PHI0 -> PHI0 completes its full PHI_HALF_CYCLES, then phi1 holds high; run_i=1 -> next phi1 fall occurs exactly PHI_HALF_CYCLES clk later.
